a_ref_cal: RTL and testbench

Calibration controller for the ring-oscillator reference generator. It closes the oscillator ring by driving the generator's mode select, then binary-searches the 9-bit delay code until the oscillator's edge count over a programmable window of system clocks matches a target. After the search it can optionally track drift with ±1 code steps. It sits between the system-clock control logic and the generator's `i_dly_sel`/`i_mode` inputs, and observes the generator's `o_osc` output.

---
 rtl/a_ref_cal.sv | 212 +++++++++++++++++++++
 tb/tb_a_ref_cal.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/a_ref_cal.sv
// a_ref_cal: ring-oscillator reference calibration controller.
// SAR search of the 9-bit delay code against a windowed edge count, then optional tracking.
module a_ref_cal #(
    parameter int WIN_W  = 16,
    parameter int SETTLE = 64
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_track_en,
    input  logic             i_osc,
    input  logic [WIN_W-1:0] i_win_len,
    input  logic [WIN_W-1:0] i_target,
    input  logic [WIN_W-1:0] i_tol,
    output logic [8:0]       o_dly_sel,
    output logic             o_mode,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_lock,
    output logic [WIN_W-1:0] o_count
);

    localparam int SW = $clog2(SETTLE + 1);
    localparam int TW = (WIN_W > SW) ? WIN_W : SW;
    localparam logic [TW-1:0] SET_LD = TW'(SETTLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE_S,
        MEAS,
        DECIDE,
        VERIFY_SETTLE,
        VERIFY,
        TRACK_SETTLE,
        TRACK
    } state_t;

    state_t           state, state_n;
    logic [TW-1:0]    timer, timer_n;
    logic [3:0]       bidx, bidx_n;
    logic [8:0]       code, code_n;
    logic [WIN_W-1:0] win, win_n;
    logic [WIN_W-1:0] tgt, tgt_n;
    logic [WIN_W-1:0] tol, tol_n;
    logic [WIN_W-1:0] cnt, cnt_n, cnt_sat;
    logic [WIN_W-1:0] count, count_n;
    logic             lock, lock_n;
    logic             done, done_n;
    logic             mode, mode_n;
    logic [2:0]       osc_q;
    logic             rise;
    logic [WIN_W:0]   hi, lo, c_ext;
    logic             in_tol, accept;
    logic [TW-1:0]    win_ld;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            osc_q <= '0;
        end else begin
            osc_q <= {osc_q[1:0], i_osc};
        end
    end

    assign rise    = osc_q[1] & ~osc_q[2];
    assign cnt_sat = (rise && cnt != '1) ? cnt + WIN_W'(1) : cnt;
    assign c_ext   = {1'b0, cnt_sat};
    assign hi      = {1'b0, tgt} + {1'b0, tol};
    assign lo      = (tgt > tol) ? {1'b0, tgt - tol} : '0;
    assign in_tol  = (c_ext >= lo) && (c_ext <= hi);
    assign win_ld  = TW'(win - WIN_W'(1));
    assign accept  = i_start &&
                     (state == IDLE || state == TRACK_SETTLE || state == TRACK);

    always_comb begin
        state_n = state;
        timer_n = timer;
        bidx_n  = bidx;
        code_n  = code;
        win_n   = win;
        tgt_n   = tgt;
        tol_n   = tol;
        cnt_n   = cnt;
        count_n = count;
        lock_n  = lock;
        done_n  = 1'b0;
        mode_n  = mode;

        if (state == MEAS || state == VERIFY || state == TRACK) begin
            cnt_n = cnt_sat;
        end

        unique case (state)
            IDLE: ;
            SETTLE_S, VERIFY_SETTLE, TRACK_SETTLE: begin
                if (timer == '0) begin
                    timer_n = win_ld;
                    cnt_n   = '0;
                    unique case (state)
                        SETTLE_S:      state_n = MEAS;
                        VERIFY_SETTLE: state_n = VERIFY;
                        default:       state_n = TRACK;
                    endcase
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            MEAS: begin
                if (timer == '0) state_n = DECIDE;
                else timer_n = timer - TW'(1);
            end
            DECIDE: begin
                // Count above target means the ring is too fast: keep the delay bit.
                code_n[bidx] = (cnt > tgt);
                timer_n      = SET_LD;
                if (bidx != 4'd0) begin
                    code_n[bidx - 4'd1] = 1'b1;
                    bidx_n  = bidx - 4'd1;
                    state_n = SETTLE_S;
                end else begin
                    state_n = VERIFY_SETTLE;
                end
            end
            VERIFY: begin
                if (timer == '0) begin
                    count_n = cnt_sat;
                    lock_n  = in_tol;
                    done_n  = 1'b1;
                    timer_n = SET_LD;
                    state_n = i_track_en ? TRACK_SETTLE : IDLE;
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            TRACK: begin
                if (timer == '0) begin
                    count_n = cnt_sat;
                    lock_n  = in_tol;
                    timer_n = SET_LD;
                    if (i_track_en) begin
                        state_n = TRACK_SETTLE;
                        if (c_ext > hi && code != 9'h1ff) code_n = code + 9'd1;
                        else if (c_ext < lo && code != 9'h000) code_n = code - 9'd1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        if (accept) begin
            win_n   = (i_win_len == '0) ? WIN_W'(1) : i_win_len;
            tgt_n   = i_target;
            tol_n   = i_tol;
            mode_n  = 1'b1;
            lock_n  = 1'b0;
            bidx_n  = 4'd8;
            code_n  = 9'h100;
            timer_n = SET_LD;
            state_n = SETTLE_S;
        end

        if (i_stop) begin
            state_n = IDLE;
            mode_n  = 1'b0;
            lock_n  = 1'b0;
            done_n  = 1'b0;
            code_n  = code;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= IDLE;
            timer <= '0;
            bidx  <= '0;
            code  <= '0;
            win   <= '0;
            tgt   <= '0;
            tol   <= '0;
            cnt   <= '0;
            count <= '0;
            lock  <= 1'b0;
            done  <= 1'b0;
            mode  <= 1'b0;
        end else begin
            state <= state_n;
            timer <= timer_n;
            bidx  <= bidx_n;
            code  <= code_n;
            win   <= win_n;
            tgt   <= tgt_n;
            tol   <= tol_n;
            cnt   <= cnt_n;
            count <= count_n;
            lock  <= lock_n;
            done  <= done_n;
            mode  <= mode_n;
        end
    end

    assign o_dly_sel = code;
    assign o_mode    = mode;
    assign o_busy    = (state != IDLE);
    assign o_done    = done;
    assign o_lock    = lock;
    assign o_count   = count;

endmodule

// File: tb/tb_a_ref_cal.sv
// tb_a_ref_cal: directed bench for a_ref_cal.
// Oscillator model emits exactly (base - code) pulses in any WIN consecutive cycles.
module tb_a_ref_cal;

    localparam int WIN_W  = 16;
    localparam int SETTLE = 8;
    localparam int WIN    = 1300;
    localparam int STEP   = SETTLE + WIN + 1;
    localparam int LAT    = 10 * STEP;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_start, i_stop, i_track_en, i_osc;
    logic [WIN_W-1:0] i_win_len, i_target, i_tol;
    logic [8:0]       o_dly_sel;
    logic             o_mode, o_busy, o_done, o_lock;
    logic [WIN_W-1:0] o_count;

    int n_chk = 0;
    int n_err = 0;
    int base  = 600;
    int acc   = 0;
    int c_osc;
    int n_done = 0;
    int cyc, d0;
    bit got;

    a_ref_cal #(.WIN_W(WIN_W), .SETTLE(SETTLE)) dut (
        .i_clk      (clk),
        .i_rstn     (rst_n),
        .i_start    (i_start),
        .i_stop     (i_stop),
        .i_track_en (i_track_en),
        .i_osc      (i_osc),
        .i_win_len  (i_win_len),
        .i_target   (i_target),
        .i_tol      (i_tol),
        .o_dly_sel  (o_dly_sel),
        .o_mode     (o_mode),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_lock     (o_lock),
        .o_count    (o_count)
    );

    always #5 clk = ~clk;

    // Accumulator pulse generator: periodic over WIN cycles for a fixed code.
    always @(negedge clk) begin
        c_osc = base - int'(o_dly_sel);
        if (c_osc < 0) c_osc = 0;
        acc += c_osc;
        if (acc >= WIN) begin
            acc  -= WIN;
            i_osc = 1'b1;
        end else begin
            i_osc = 1'b0;
        end
        if (rst_n && o_done) n_done++;
    end

    task automatic check(input string tag, input int got_v, input int exp_v);
        n_chk++;
        if (got_v != exp_v) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got_v, exp_v);
        end
    endtask

    task automatic run_cal(output int c, output bit ok);
        c  = 0;
        ok = 0;
        i_start = 1'b1;
        while (!ok && c < LAT + 200) begin
            @(negedge clk);
            c++;
            i_start = 1'b0;
            if (o_done) ok = 1;
        end
        if (!ok) check("done_timeout", 0, 1);
    endtask

    initial begin
        rst_n      = 1'b0;
        i_start    = 1'b0;
        i_stop     = 1'b0;
        i_track_en = 1'b0;
        i_osc      = 1'b0;
        i_win_len  = WIN_W'(WIN);
        i_target   = 16'd300;
        i_tol      = 16'd1;
        repeat (3) @(negedge clk);
        check("rst_dly", o_dly_sel, 0);
        check("rst_mode", o_mode, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_lock", o_lock, 0);
        check("rst_count", o_count, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of the first window.
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (100) @(negedge clk);
        check("meas_busy", o_busy, 1);
        check("meas_mode", o_mode, 1);
        check("meas_dly", o_dly_sel, 256);
        #2 rst_n = 1'b0;
        #1;
        check("arst_dly", o_dly_sel, 0);
        check("arst_mode", o_mode, 0);
        check("arst_busy", o_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", o_busy, 0);

        // Full search with stray start pulses in SETTLE and MEAS.
        i_track_en = 1'b1;
        i_start    = 1'b1;
        cyc = 0;
        got = 0;
        while (!got && cyc < LAT + 200) begin
            @(negedge clk);
            cyc++;
            i_start = (cyc == 3 || cyc == 500);
            if (cyc == 1) check("code_s1", o_dly_sel, 256);
            if (cyc == STEP + 1) check("code_s2", o_dly_sel, 384);
            if (cyc == 2 * STEP + 1) check("code_s3", o_dly_sel, 320);
            if (o_done) got = 1;
        end
        i_start = 1'b0;
        if (!got) check("done_timeout", 0, 1);
        check("latency", (cyc >= LAT - 1 && cyc <= LAT + 1) ? 1 : 0, 1);
        check("lock_code", o_dly_sel, 299);
        check("lock_count", o_count, 301);
        check("lock_flag", o_lock, 1);
        base = 620;
        @(negedge clk);
        check("done_pulse", o_done, 0);
        check("done_once", n_done, 1);

        // Drift: code should walk up to 319.
        repeat (23 * (SETTLE + WIN)) @(negedge clk);
        check("trk_code", o_dly_sel, 319);
        check("trk_lock", o_lock, 1);
        check("trk_count", o_count, 301);
        check("trk_nodone", n_done, 1);
        check("trk_busy", o_busy, 1);

        // Restart from tracking, then abort.
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check("restart_code", o_dly_sel, 256);
        i_stop = 1'b1;
        @(negedge clk);
        i_stop = 1'b0;
        check("stop_busy", o_busy, 0);
        check("stop_mode", o_mode, 0);
        check("stop_lock", o_lock, 0);
        check("stop_dly", o_dly_sel, 256);

        // Abort during the third search step.
        base       = 600;
        i_track_en = 1'b0;
        i_start    = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (2 * STEP + 99) @(negedge clk);
        check("ab_code", o_dly_sel, 320);
        d0 = n_done;
        i_stop = 1'b1;
        @(negedge clk);
        i_stop = 1'b0;
        check("ab_busy", o_busy, 0);
        check("ab_mode", o_mode, 0);
        check("ab_dly", o_dly_sel, 320);
        repeat (LAT - 2 * STEP + 500) @(negedge clk);
        check("ab_nodone", n_done, d0);
        check("ab_idle", o_busy, 0);

        // Search saturating high.
        i_target = 16'd0;
        run_cal(cyc, got);
        check("sat0_code", o_dly_sel, 511);
        check("sat0_count", o_count, 89);
        check("sat0_lock", o_lock, 0);
        @(negedge clk);
        check("sat0_idle", o_busy, 0);
        check("sat0_mode", o_mode, 1);

        // Search saturating low.
        i_target = 16'd700;
        run_cal(cyc, got);
        check("sat700_code", o_dly_sel, 0);
        check("sat700_count", o_count, 600);
        check("sat700_lock", o_lock, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
